// File: rtl/res_ser_pkg.sv
// Shared constants and FSM encoding for the result byte serializer.
// Optional feature macro: RES_SER_PARITY_EN appends an XOR parity byte to every word.
package res_ser_pkg;

    localparam int unsigned DATA_W = 56;
    localparam int unsigned BYTE_W = 8;
`ifdef RES_SER_PARITY_EN
    localparam int unsigned NBYTES = DATA_W / BYTE_W + 1;
`else
    localparam int unsigned NBYTES = DATA_W / BYTE_W;
`endif
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned IDX_W  = $clog2(NBYTES);
    localparam int unsigned DROP_W = 16;

    localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/res_sync_fifo.sv
// Single-clock FIFO with occupancy count; Depth must be a power of two so pointers wrap freely.
module res_sync_fifo #(
    parameter int unsigned Width = 56,
    parameter int unsigned Depth = 8,
    parameter int unsigned AddrW = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AddrW:0]   level_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   level_q, level_d;

    // Pointer and occupancy next-state; push+pop together leaves the level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        unique case ({push_i, pop_i})
            2'b10:   level_d = level_q + (AddrW + 1)'(1);
            2'b01:   level_d = level_q - (AddrW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (level_q == (AddrW + 1)'(Depth));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;

endmodule

// File: rtl/result_byte_serializer.sv
// Buffers product words and streams them out LSB byte first over valid/ready.
// Upstream cannot stall: words arriving with a full FIFO and no pop are dropped and counted.
// Optional feature macro: RES_SER_PARITY_EN adds a trailing XOR parity byte carrying out_last.
module result_byte_serializer
    import res_ser_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W:0]   fifo_level,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ovf_q, ovf_d;
`ifdef RES_SER_PARITY_EN
    logic [BYTE_W-1:0] parity_q, parity_d;
`endif

    logic              accept;
    logic              pop;
    logic              push;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd;

    res_sync_fifo #(
        .Width (DATA_W),
        .Depth (DEPTH),
        .AddrW (ADDR_W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_i    (push),
        .wr_data_i (in_data),
        .pop_i     (pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign accept = valid_q && out_ready;

    // Serializer next-state: load from FIFO, shift on accept, reload on last byte without a bubble.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        pop     = 1'b0;
`ifdef RES_SER_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                pop = !fifo_empty;
            end
            SEND: begin
                if (accept) begin
                    if (last_q) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        shift_d = shift_q >> BYTE_W;
                        idx_d   = idx_q + IDX_W'(1);
                        last_d  = (idx_d == LAST_IDX);
`ifdef RES_SER_PARITY_EN
                        parity_d = parity_q ^ shift_q[BYTE_W-1:0];
                        // Once the data bytes are exhausted the low byte carries the parity.
                        if (idx_d == LAST_IDX) begin
                            shift_d[BYTE_W-1:0] = parity_q ^ shift_q[BYTE_W-1:0];
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            state_d = SEND;
            shift_d = fifo_rd;
            idx_d   = '0;
            valid_d = 1'b1;
            last_d  = (LAST_IDX == '0);
`ifdef RES_SER_PARITY_EN
            parity_d = '0;
`endif
        end
    end

    // Push acceptance and drop accounting; a same-cycle pop frees the slot for a full FIFO.
    always_comb begin
        push   = in_valid && (!fifo_full || pop);
        drop   = in_valid && !push;
        drop_d = drop_q;
        ovf_d  = ovf_q | drop;
        if (drop && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // FSM, shift register and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
`ifdef RES_SER_PARITY_EN
            parity_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
`ifdef RES_SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign out_data  = shift_q[BYTE_W-1:0];
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign drop_cnt  = drop_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_result_byte_serializer.sv
// Randomized and directed bench for result_byte_serializer with a queue-based reference model.
// Honors RES_SER_PARITY_EN the same way the design does.
module tb_result_byte_serializer;

    localparam int DW = 56;
`ifdef RES_SER_PARITY_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif
    localparam int MDEPTH = 8;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_byte_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [3:0]    fifo_level;
    logic [15:0]   drop_cnt;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    exp_byte_t sb[$];
    int        m_level = 0;
    int        m_rem   = 0;
    int        m_drop  = 0;
    bit        m_ovf   = 1'b0;

    result_byte_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected byte stream of one word: LSB byte first, optional XOR byte last.
    task automatic push_expected(input logic [DW-1:0] w);
        exp_byte_t e;
        logic [7:0] par;
        par = '0;
        for (int i = 0; i < DW / 8; i++) begin
            e.b = w[8*i +: 8];
            e.last = (i == NB - 1);
            par ^= e.b;
            sb.push_back(e);
        end
        if (NB > DW / 8) begin
            e.b = par;
            e.last = 1'b1;
            sb.push_back(e);
        end
    endtask

    // Cycle model: a word is "in flight" with m_rem bytes left; m_level words wait behind it.
    initial begin
        bit busy, acc, fin, pop;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                sb.delete();
                m_level = 0;
                m_rem   = 0;
                m_drop  = 0;
                m_ovf   = 1'b0;
            end else begin
                busy = (m_rem > 0);
                acc  = busy && out_ready;
                fin  = acc && (m_rem == 1);
                if (acc) m_rem--;
                pop = (m_level > 0) && (!busy || fin);
                if (pop) begin
                    m_level--;
                    m_rem = NB;
                end
                if (in_valid) begin
                    if (m_level < MDEPTH) begin
                        m_level++;
                        push_expected(in_data);
                    end else begin
                        if (m_drop < 65535) m_drop++;
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: mid-cycle compare of status against the model and of accepted bytes against the scoreboard.
    initial begin
        exp_byte_t e;
        forever begin
            @(negedge clk);
            chk("out_valid", 64'(out_valid), 64'(m_rem > 0));
            chk("fifo_level", 64'(fifo_level), 64'(m_level));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (out_valid && out_ready && !rst) begin
                if (sb.size() == 0) begin
                    chk("unexpected_byte", 64'(out_data), 64'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.b));
                    chk("out_last", 64'(out_last), 64'(e.last));
                end
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for the model to go empty; toggle_ready emulates alternating backpressure.
    task automatic drain(input int budget, input bit toggle_ready);
        int n;
        n = 0;
        while ((m_rem > 0 || m_level > 0) && n < budget) begin
            if (toggle_ready) out_ready = ~out_ready;
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < budget), 64'd1);
        tick();
    endtask

    initial begin
        logic [DW-1:0] w;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_level", 64'(fifo_level), 64'd0);

        // Single word, full-rate sink
        out_ready = 1'b1;
        send_word(56'h0123456789ABCD);
        drain(50, 1'b0);

        // Alternating backpressure
        out_ready = 1'b0;
        send_word(56'h0123456789ABCD);
        drain(100, 1'b1);

        // Back-to-back words, no bubble at boundary
        out_ready = 1'b1;
        in_data   = 56'h00112233445566;
        in_valid  = 1'b1;
        tick();
        in_data   = 56'hFFEEDDCCBBAA99;
        tick();
        in_valid  = 1'b0;
        drain(100, 1'b0);

        // Overflow: one word held in the shifter, then ten pushes into a stalled sink
        out_ready = 1'b0;
        send_word(56'h0);
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("ovf_level", 64'(fifo_level), 64'd8);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        tick();
        out_ready = 1'b1;
        drain(200, 1'b0);
        chk("ovf_after_drain", 64'(overflow), 64'd1);

        // Reset in the middle of the third byte with words still buffered
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_level", 64'(fifo_level), 64'd0);
        chk("midrst_drop", 64'(drop_cnt), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic, including zero-valued words and bursts that overflow
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 30);
            w = {$urandom, $urandom};
            in_data   = ($urandom_range(0, 9) == 0) ? '0 : w;
            out_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(300, 1'b0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
